// File: rtl/riscv_exec_pkg.sv
// Shared opcode/funct constants and the ALU operation encoding for the
// integer execute pipe.
package riscv_exec_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // Operation selected by funct3 when the alternate funct7 bit is clear.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational RV32I/RV64I integer ALU; shift amount is the low SHW bits of b.
module riscv_alu
  import riscv_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $signed(a) >>> shamt;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/riscv_exec_pipe.sv
// Two-stage OP/OP-IMM execute pipe: S1 holds decoded operands, S2 holds the
// registered ALU result. Valid/ready on both sides with full-throughput stalls.
module riscv_exec_pipe
  import riscv_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // rs1 index is resolved by the register file upstream.
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr[19:15];

  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_b;
  logic            dec_illegal;

  always_comb begin
    dec_op      = ALU_ADD;
    dec_b       = rs2_data;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          dec_op = base_op(f3);
        end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
          dec_op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == F3_SRL_SRA) begin
          dec_op = ALU_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_b = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (f3)
          F3_SLL: begin
            dec_op      = ALU_SLL;
            dec_illegal = (instr[31:20+SHW] != '0);
          end
          // Bit 30 is the only permitted high immediate bit; it selects SRAI.
          F3_SRL_SRA: begin
            dec_op      = instr[30] ? ALU_SRA : ALU_SRL;
            dec_illegal = instr[31] || (instr[29:20+SHW] != '0);
          end
          default: dec_op = base_op(f3);
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic            s1_valid_reg;
  alu_op_e         s1_op_reg;
  logic [XLEN-1:0] s1_a_reg;
  logic [XLEN-1:0] s1_b_reg;
  logic [4:0]      s1_rd_reg;
  logic            s1_illegal_reg;

  logic            out_valid_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      rd_addr_reg;
  logic            illegal_reg;

  logic s2_free;
  logic s1_free;
  logic accept;
  assign s2_free  = !out_valid_reg || out_ready;
  assign s1_free  = !s1_valid_reg || s2_free;
  assign in_ready = rst_n && s1_free;
  assign accept   = in_valid && in_ready;

  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] result_next;

  riscv_alu #(.XLEN(XLEN)) u_alu (
    .op (s1_op_reg),
    .a  (s1_a_reg),
    .b  (s1_b_reg),
    .y  (alu_y)
  );

  // Illegal ops and writes to x0 both report a zero result.
  assign result_next = (s1_illegal_reg || s1_rd_reg == 5'd0) ? '0 : alu_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_op_reg      <= ALU_ADD;
      s1_a_reg       <= '0;
      s1_b_reg       <= '0;
      s1_rd_reg      <= '0;
      s1_illegal_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      result_reg     <= '0;
      rd_addr_reg    <= '0;
      illegal_reg    <= 1'b0;
    end else begin
      if (s2_free) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          result_reg  <= result_next;
          rd_addr_reg <= s1_rd_reg;
          illegal_reg <= s1_illegal_reg;
        end
      end
      if (s1_free) begin
        s1_valid_reg <= accept;
        if (accept) begin
          s1_op_reg      <= dec_op;
          s1_a_reg       <= rs1_data;
          s1_b_reg       <= dec_b;
          s1_rd_reg      <= instr[11:7];
          s1_illegal_reg <= dec_illegal;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign rd_addr   = rd_addr_reg;
  assign illegal   = illegal_reg;

endmodule

// File: doc/riscv_exec_pipe.md
Name: riscv_exec_pipe

Overview:
Parametrised, two-stage pipelined integer execute unit for the RV32I/RV64I datapath. It accepts one instruction and its two register operands per cycle over a valid/ready handshake. It decodes R-type (OP) and I-type (OP-IMM) arithmetic and logic instructions, computes the result, and presents it with the destination register address. Backpressure is supported end to end; it sits between register-file read and writeback.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
SHW, $clog2(XLEN), shift-amount width; localparam, not overridable.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instruction and operands are valid
in_ready  out  1  unit accepts the input this cycle
instr  in  32  raw instruction word
rs1_data  in  XLEN  rs1 operand
rs2_data  in  XLEN  rs2 operand; ignored for I-type
out_valid  out  1  result is valid
out_ready  in  1  downstream accepts the result
result  out  XLEN  ALU result, registered
rd_addr  out  5  destination register (instr[11:7])
illegal  out  1  instruction is not a supported OP/OP-IMM encoding

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a clock edge: both stage-valid bits clear, out_valid=0, result=0, rd_addr=0, illegal=0. in_ready=0 whenever rst_n=0. A reset mid-stream discards all in-flight instructions with no output.
- Transfer rules: input transfers when in_valid&&in_ready; output transfers when out_valid&&out_ready.
- Stage 1 (S1) registers the decoded op, operand A, operand B, rd and the illegal flag. Stage 2 (S2) registers result, rd_addr and illegal; out_valid is the S2 valid bit.
- Stall logic: s2_free = !out_valid || out_ready; s1_free = !s1_valid || s2_free; in_ready = s1_free (when out of reset).
- Latency and throughput: 2 cycles from accept to out_valid with no stall; throughput 1 per cycle.
- While out_valid=1 and out_ready=0, result, rd_addr and illegal hold stable. No instruction is dropped or duplicated, and order is preserved.
- Decode: opcode 0110011 is R-type, with B=rs2_data. Opcode 0010011 is I-type, with B=sign-extended instr[31:20] to XLEN.
- funct3 mapping: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- funct7 for R-type: 0000000 is the base op; 0100000 is legal only with funct3 000 (SUB) or 101 (SRA). Any other value is illegal.
- I-type: there is no SUBI, so funct3 000 is always ADDI. For SLLI/SRLI/SRAI, instr bits [31:20+SHW] must be all zero, except bit 30, which selects SRAI (legal only with funct3 101). Any other pattern is illegal.
- Any other opcode is illegal.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. Shift amount = B[SHW-1:0]. SRA is arithmetic. SLT is a signed compare and SLTU an unsigned compare; both produce 0 or 1, zero-extended.
- Illegal instructions: still flow through the pipeline with illegal=1, result=0 and rd_addr from instr[11:7].
- rd=x0: the instruction is passed through normally, but result is forced to 0.
- Simultaneous events: S1 and S2 may both advance in the same cycle an output is consumed, so back-to-back operation never bubbles when out_ready=1.

Decomposition:
- Package riscv_exec_pkg: OPC_OP/OPC_OP_IMM constants, F3_* funct3 constants, F7_BASE/F7_ALT constants, and alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- Sub-module riscv_alu: combinational, parametrised by XLEN, with inputs alu_op_e, a and b and output y. It is instantiated in S2. Decode and the handshake stay in riscv_exec_pipe.

Test Plan:
1. Reset for 2 cycles, then accept ADD x4 (instr 0x00208233, rs1=5, rs2=8) -> out_valid 2 cycles later, result=0x0000000D, rd_addr=4, illegal=0.
2. Back-to-back, out_ready=1: SUB (0x40308333, 0x15, 0x8) then SRA (0x4020D2B3, 0x80000000, 1) then SLTU (0x0020B2B3, 0xFFFFFFFF, 1) -> results 0x0000000D, 0xC0000000, 0 on consecutive cycles.
3. I-type: ADDI imm=-1 (0xFFF08093) with rs1=0 -> 0xFFFFFFFF. SLLI shamt=4 (0x00409093) with rs1=1 -> 0x10. SRLI with bit 25 set -> illegal=1, result=0.
4. Backpressure: out_ready=0 for 4 cycles while in_valid=1 with 3 distinct ADDs -> in_ready falls after 2 accepts, result is held stable, and all 3 results emerge in order once out_ready=1.
5. Illegal opcode 0x0000007F and rd=x0 ADD (0x00208033, 5, 8) -> first gives illegal=1, result=0; second gives illegal=0, result=0.
6. rst_n=0 for one cycle while both stages are full -> next cycle out_valid=0, result=0; no stale outputs appear after reset is released.
